// File: rtl/mips_run_ctrl.sv
// Run controller for a small MIPS core: streams code into instruction memory,
// then starts, counts and stops execution of the core.
module mips_run_ctrl #(
  parameter int AW = 10,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_req,
  input  logic          run_req,
  input  logic          abort,
  input  logic          ld_valid,
  input  logic [DW-1:0] ld_data,
  input  logic          ld_last,
  output logic          ld_ready,
  input  logic          hlt,
  output logic          imem_we,
  output logic [AW-1:0] imem_addr,
  output logic [DW-1:0] imem_wdata,
  output logic          core_en,
  output logic          core_rst,
  output logic [1:0]    state,
  output logic          done,
  output logic          err,
  output logic [31:0]   cycle_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    LOAD = 2'b01,
    RUN  = 2'b10,
    HALT = 2'b11
  } state_e;

  localparam logic [AW-1:0] PTR_MAX = '1;

  state_e        st;
  logic [AW-1:0] wptr;
  logic          first_run;

  assign state      = st;
  assign ld_ready   = (st == LOAD);
  assign imem_we    = ld_valid & ld_ready;
  assign imem_addr  = wptr;
  assign imem_wdata = ld_data;
  // Enable falls in the very cycle the halt opcode is decoded, so the core
  // never advances past it.
  assign core_rst   = (st == RUN) & first_run;
  assign core_en    = (st == RUN) & ~first_run & ~hlt;

  // NOTE: all state updates use <= so every branch sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st        <= IDLE;
      wptr      <= '0;
      first_run <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      cycle_cnt <= '0;
    end else begin
      done <= 1'b0;
      if (core_en && cycle_cnt != 32'hFFFF_FFFF)
        cycle_cnt <= cycle_cnt + 32'd1;

      if (abort) begin
        st <= IDLE;
      end else begin
        unique case (st)
          IDLE, HALT: begin
            if (load_req) begin
              st   <= LOAD;
              wptr <= '0;
              err  <= 1'b0;
            end else if (run_req) begin
              st        <= RUN;
              first_run <= 1'b1;
              cycle_cnt <= '0;
            end
          end
          LOAD: begin
            if (imem_we) begin
              // Pointer parks at the top address rather than wrapping.
              if (wptr != PTR_MAX)
                wptr <= wptr + 1'b1;
              if (ld_last) begin
                st <= IDLE;
              end else if (wptr == PTR_MAX) begin
                err <= 1'b1;
                st  <= IDLE;
              end
            end
          end
          RUN: begin
            if (first_run) begin
              first_run <= 1'b0;
            end else if (hlt) begin
              st   <= HALT;
              done <= 1'b1;
            end
          end
          default: st <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mips_run_ctrl.sv
// Directed bench for mips_run_ctrl: a default instance plus an AW=2 instance
// sharing the same stimulus for the overflow case.
module tb_mips_run_ctrl;

  logic        clk;
  logic        rst_n;
  logic        load_req, run_req, abort;
  logic        ld_valid, ld_last, hlt;
  logic [31:0] ld_data;

  logic        ld_ready, imem_we, core_en, core_rst, done, err;
  logic [9:0]  imem_addr;
  logic [31:0] imem_wdata, cycle_cnt;
  logic [1:0]  state;

  logic        s_ld_ready, s_imem_we, s_core_en, s_core_rst, s_done, s_err;
  logic [1:0]  s_imem_addr;
  logic [31:0] s_imem_wdata, s_cycle_cnt;
  logic [1:0]  s_state;

  int n_cmp = 0;
  int n_bad = 0;

  mips_run_ctrl #(.AW(10), .DW(32)) u_dut (
    .clk(clk), .rst_n(rst_n), .load_req(load_req), .run_req(run_req),
    .abort(abort), .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last),
    .ld_ready(ld_ready), .hlt(hlt), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .core_en(core_en), .core_rst(core_rst),
    .state(state), .done(done), .err(err), .cycle_cnt(cycle_cnt)
  );

  mips_run_ctrl #(.AW(2), .DW(32)) u_small (
    .clk(clk), .rst_n(rst_n), .load_req(load_req), .run_req(run_req),
    .abort(abort), .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last),
    .ld_ready(s_ld_ready), .hlt(hlt), .imem_we(s_imem_we),
    .imem_addr(s_imem_addr), .imem_wdata(s_imem_wdata), .core_en(s_core_en),
    .core_rst(s_core_rst), .state(s_state), .done(s_done), .err(s_err),
    .cycle_cnt(s_cycle_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int en_cycles;
    rst_n = 1'b0; load_req = 0; run_req = 0; abort = 0;
    ld_valid = 0; ld_last = 0; hlt = 0; ld_data = '0;

    // Reset state
    #12;
    check("rst_state", state, 2'b00);
    check("rst_ld_ready", ld_ready, 1'b0);
    check("rst_core_en", core_en, 1'b0);
    check("rst_cycle_cnt", cycle_cnt, 32'd0);
    check("rst_err", err, 1'b0);
    rst_n = 1'b1;
    tick();
    check("idle_after_rst", state, 2'b00);

    // Load three words with gaps on ld_valid
    load_req = 1; tick(); load_req = 0;
    check("load_state", state, 2'b01);
    check("load_ready", ld_ready, 1'b1);
    ld_valid = 1; ld_data = 32'h11; #1;
    check("w0_we", imem_we, 1'b1);
    check("w0_addr", imem_addr, 10'd0);
    check("w0_data", imem_wdata, 32'h11);
    tick(); ld_valid = 0; #1;
    check("gap0_we", imem_we, 1'b0);
    check("gap0_addr", imem_addr, 10'd1);
    tick(); ld_valid = 1; ld_data = 32'h22; #1;
    check("w1_we", imem_we, 1'b1);
    check("w1_addr", imem_addr, 10'd1);
    tick(); ld_valid = 0; tick();
    check("gap1_addr", imem_addr, 10'd2);
    ld_valid = 1; ld_data = 32'h33; ld_last = 1; #1;
    check("w2_addr", imem_addr, 10'd2);
    check("w2_data", imem_wdata, 32'h33);
    tick(); ld_valid = 0; ld_last = 0; #1;
    check("load_done_state", state, 2'b00);
    check("load_done_err", err, 1'b0);
    check("load_done_we", imem_we, 1'b0);

    // Overflow on the AW=2 instance: four words fill it, fifth refused
    load_req = 1; tick(); load_req = 0;
    for (int i = 0; i < 4; i++) begin
      ld_valid = 1; ld_data = 32'h100 + i; #1;
      check("ovf_we", s_imem_we, 1'b1);
      check("ovf_addr", s_imem_addr, i[1:0]);
      tick();
    end
    check("ovf_state", s_state, 2'b00);
    check("ovf_err", s_err, 1'b1);
    check("ovf_ready", s_ld_ready, 1'b0);
    check("ovf_addr_nowrap", s_imem_addr, 2'd3);
    #1;
    check("ovf_5th_we", s_imem_we, 1'b0);
    tick(); ld_valid = 0;
    check("ovf_err_sticky", s_err, 1'b1);

    // Abort mid-LOAD keeps pointer; reload restarts at 0 and clears err
    check("big_still_load", state, 2'b01);
    check("big_ptr", imem_addr, 10'd5);
    abort = 1; tick(); abort = 0;
    check("abort_ld_state", state, 2'b00);
    check("abort_ld_ready", ld_ready, 1'b0);
    check("abort_ld_ptr", imem_addr, 10'd5);
    load_req = 1; tick(); load_req = 0;
    check("reload_addr", imem_addr, 10'd0);
    check("reload_err_clr", s_err, 1'b0);
    abort = 1; tick(); abort = 0;

    // Run, halt raised on the 11th RUN cycle
    run_req = 1; tick(); run_req = 0;
    check("run_state", state, 2'b10);
    check("run_core_rst", core_rst, 1'b1);
    check("run_core_en0", core_en, 1'b0);
    check("run_cnt_clr", cycle_cnt, 32'd0);
    en_cycles = 0;
    for (int c = 2; c <= 10; c++) begin
      tick();
      if (core_en) en_cycles++;
      if (core_rst) en_cycles += 100;
    end
    check("run_en_cycles", en_cycles, 9);
    tick(); hlt = 1; #1;
    check("hlt_en_drop", core_en, 1'b0);
    check("hlt_state_run", state, 2'b10);
    tick();
    check("halt_state", state, 2'b11);
    check("halt_done", done, 1'b1);
    check("halt_cnt", cycle_cnt, 32'd9);
    tick();
    check("halt_done_once", done, 1'b0);
    check("halt_cnt_hold", cycle_cnt, 32'd9);
    check("halt_en", core_en, 1'b0);

    // Priority in HALT: abort wins over load and run
    load_req = 1; run_req = 1; abort = 1; tick();
    load_req = 0; run_req = 0; abort = 0;
    check("prio_abort", state, 2'b00);
    // hlt still high: ignored in IDLE and first RUN cycle
    run_req = 1; tick(); run_req = 0;
    check("hlt_ign_first", state, 2'b10);
    check("hlt_first_rst", core_rst, 1'b1);
    tick();
    check("hlt_second_state", state, 2'b10);
    check("hlt_second_en", core_en, 1'b0);
    tick(); hlt = 0;
    check("halt2_state", state, 2'b11);
    check("halt2_cnt", cycle_cnt, 32'd0);
    load_req = 1; run_req = 1; tick(); load_req = 0; run_req = 0;
    check("prio_load", state, 2'b01);
    abort = 1; tick(); abort = 0;

    // Abort mid-RUN
    run_req = 1; tick(); run_req = 0;
    tick(); tick();
    check("mid_run_cnt", cycle_cnt, 32'd1);
    abort = 1; tick(); abort = 0;
    check("abort_run_state", state, 2'b00);
    check("abort_run_en", core_en, 1'b0);
    check("abort_run_cnt", cycle_cnt, 32'd2);
    tick();
    check("idle_cnt_hold", cycle_cnt, 32'd2);

    // Asynchronous reset mid-RUN
    run_req = 1; tick(); run_req = 0;
    tick(); tick();
    check("pre_rst_en", core_en, 1'b1);
    #2 rst_n = 0; #1;
    check("arst_state", state, 2'b00);
    check("arst_en", core_en, 1'b0);
    check("arst_cnt", cycle_cnt, 32'd0);
    check("arst_done", done, 1'b0);
    check("arst_rst", core_rst, 1'b0);
    #2 rst_n = 1;
    tick();
    check("post_rst_idle", state, 2'b00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
